// File: rtl/qos_req_ager_if.sv
// ---------------------------------------------------------------------------
// qos_req_ager_if
// Purpose : bundles the per-lane request handshake between the upstream
//           requesters, the QoS ager and the downstream arbiter.
// Signals :
//   in_valid_i   [N]    upstream request valid per lane
//   in_prio_i    [4N]   base priority per lane, lane k at [4k+3:4k]
//   in_ready_o   [N]    lane can accept a request
//   out_valid_o  [N]    held request presented to the arbiter
//   out_prio_o   [4N]   effective (aged) priority per lane
//   out_urgent_o [N]    lane has waited past the starvation limit
//   out_ready_i  [N]    arbiter accepted the lane this cycle
// Modports: slave = the ager itself, master = the environment around it.
// ---------------------------------------------------------------------------
interface qos_req_ager_if #(
  parameter int NUM_REQUESTERS = 2
);
  logic [NUM_REQUESTERS-1:0]   in_valid_i;
  logic [4*NUM_REQUESTERS-1:0] in_prio_i;
  logic [NUM_REQUESTERS-1:0]   in_ready_o;
  logic [NUM_REQUESTERS-1:0]   out_valid_o;
  logic [4*NUM_REQUESTERS-1:0] out_prio_o;
  logic [NUM_REQUESTERS-1:0]   out_urgent_o;
  logic [NUM_REQUESTERS-1:0]   out_ready_i;

  modport slave (
    input  in_valid_i, in_prio_i, out_ready_i,
    output in_ready_o, out_valid_o, out_prio_o, out_urgent_o
  );

  modport master (
    output in_valid_i, in_prio_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_prio_o, out_urgent_o
  );
endinterface

// File: rtl/qos_req_ager.sv
// ---------------------------------------------------------------------------
// qos_req_ager
// Purpose : holds one request per lane and raises its priority the longer it
//           waits for the arbiter, flagging lanes that wait too long as
//           urgent and counting how many entries ever reached that point.
// Ports   :
//   clk_i            single clock, all state on the rising edge
//   rst_ni           asynchronous active-low reset
//   qos_enable_i     enables priority escalation and urgency reporting
//   bus_if (slave)   per-lane request/grant handshake (see qos_req_ager_if)
//   starve_events_o  running count of entries that reached STARVE_LIMIT
// ---------------------------------------------------------------------------
module qos_req_ager #(
  parameter int NUM_REQUESTERS = 2,
  parameter int AGE_W          = 8,
  parameter int AGE_STEP       = 4,
  parameter int STARVE_LIMIT   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 qos_enable_i,
  qos_req_ager_if.slave        bus_if,
  output logic [31:0]          starve_events_o
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} lane_state_e;

  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] STEP_V   = AGE_W'(AGE_STEP);
  localparam logic [AGE_W-1:0] LIMIT_V  = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] LIMIT_M1 = AGE_W'(STARVE_LIMIT - 1);

  lane_state_e      r_state     [NUM_REQUESTERS];
  lane_state_e      w_state_nxt [NUM_REQUESTERS];
  logic [AGE_W-1:0] r_age       [NUM_REQUESTERS];
  logic [AGE_W-1:0] w_age_nxt   [NUM_REQUESTERS];
  logic [AGE_W-1:0] w_age_inc   [NUM_REQUESTERS];
  logic [3:0]       r_base      [NUM_REQUESTERS];
  logic [3:0]       w_base_nxt  [NUM_REQUESTERS];
  logic [3:0]       r_eff       [NUM_REQUESTERS];
  logic [3:0]       w_eff_nxt   [NUM_REQUESTERS];

  logic [NUM_REQUESTERS-1:0] w_accept;
  logic [NUM_REQUESTERS-1:0] w_load;
  logic [NUM_REQUESTERS-1:0] w_starve;
  logic [31:0]               r_starve_cnt;
  logic [31:0]               w_starve_sum;

  // Lane state, age and both priority copies. The base copy is what the
  // requester asked for; the escalated copy keeps its progress even while
  // escalation is switched off so re-enabling resumes where it stopped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        r_state[k] <= ST_EMPTY;
        r_age[k]   <= '0;
        r_base[k]  <= '0;
        r_eff[k]   <= '0;
      end
      r_starve_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_age[k]   <= w_age_nxt[k];
        r_base[k]  <= w_base_nxt[k];
        r_eff[k]   <= w_eff_nxt[k];
      end
      r_starve_cnt <= r_starve_cnt + w_starve_sum;
    end
  end

  // Per-lane transitions. A load wins over a plain accept so that an accept
  // and a new request in the same cycle simply replace the entry without a
  // bubble. Ageing only happens when the age really moves, so a saturated
  // counter neither escalates nor re-fires the starvation event.
  always_comb begin
    w_starve_sum = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      w_state_nxt[k] = r_state[k];
      w_age_nxt[k]   = r_age[k];
      w_base_nxt[k]  = r_base[k];
      w_eff_nxt[k]   = r_eff[k];
      w_starve[k]    = 1'b0;
      w_age_inc[k]   = r_age[k] + 1'b1;
      if (w_load[k]) begin
        w_state_nxt[k] = ST_HELD;
        w_age_nxt[k]   = '0;
        w_base_nxt[k]  = bus_if.in_prio_i[4*k +: 4];
        w_eff_nxt[k]   = bus_if.in_prio_i[4*k +: 4];
      end else if (w_accept[k]) begin
        w_state_nxt[k] = ST_EMPTY;
        w_age_nxt[k]   = '0;
      end else if (r_state[k] == ST_HELD && r_age[k] != AGE_MAX) begin
        w_age_nxt[k] = w_age_inc[k];
        if (qos_enable_i && (w_age_inc[k] % STEP_V) == '0 && r_eff[k] != 4'hF)
          w_eff_nxt[k] = r_eff[k] + 4'd1;
        if (r_age[k] == LIMIT_M1)
          w_starve[k] = 1'b1;
      end
      w_starve_sum = w_starve_sum + {31'd0, w_starve[k]};
    end
  end

  // Handshake and presentation. When escalation is off the arbiter sees the
  // requester's own priority, and urgency is suppressed.
  always_comb begin
    w_accept            = '0;
    w_load              = '0;
    bus_if.in_ready_o   = '0;
    bus_if.out_valid_o  = '0;
    bus_if.out_prio_o   = '0;
    bus_if.out_urgent_o = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      bus_if.out_valid_o[k]   = (r_state[k] == ST_HELD);
      w_accept[k]             = (r_state[k] == ST_HELD) && bus_if.out_ready_i[k];
      bus_if.in_ready_o[k]    = (r_state[k] == ST_EMPTY) || w_accept[k];
      w_load[k]               = bus_if.in_valid_i[k] && bus_if.in_ready_o[k];
      bus_if.out_prio_o[4*k +: 4] = qos_enable_i ? r_eff[k] : r_base[k];
      bus_if.out_urgent_o[k]  = qos_enable_i && (r_state[k] == ST_HELD) && (r_age[k] >= LIMIT_V);
    end
  end

  assign starve_events_o = r_starve_cnt;

endmodule

// File: tb/tb_qos_req_ager.sv
// ---------------------------------------------------------------------------
// tb_qos_req_ager
// Directed bench for qos_req_ager with default parameters. Inputs are driven
// and outputs sampled on the falling clock edge, half a period away from the
// rising edge that updates the design.
// ---------------------------------------------------------------------------
module tb_qos_req_ager;

  logic        clk = 1'b0;
  logic        rstN;
  logic        qosEnable;
  logic [31:0] starveEvents;
  int          errorCount = 0;
  int          checkCount = 0;

  qos_req_ager_if #(.NUM_REQUESTERS(2)) bus ();

  qos_req_ager #(
    .NUM_REQUESTERS(2),
    .AGE_W(8),
    .AGE_STEP(4),
    .STARVE_LIMIT(32)
  ) dut (
    .clk_i(clk),
    .rst_ni(rstN),
    .qos_enable_i(qosEnable),
    .bus_if(bus),
    .starve_events_o(starveEvents)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] prio0,
                               input logic [3:0] prio1, input logic [1:0] ready);
    bus.in_valid_i  = valid;
    bus.in_prio_i   = {prio1, prio0};
    bus.out_ready_i = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      else begin
        errorCount++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstN      = 1'b0;
    qosEnable = 1'b1;
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    tick(2);

    // Reset state, plus arbiter grants on empty lanes must do nothing.
    checkOutput("rst_valid",  {30'd0, bus.out_valid_o}, 32'd0);
    checkOutput("rst_prio",   {24'd0, bus.out_prio_o}, 32'd0);
    checkOutput("rst_urgent", {30'd0, bus.out_urgent_o}, 32'd0);
    checkOutput("rst_starve", starveEvents, 32'd0);
    checkOutput("rst_ready",  {30'd0, bus.in_ready_o}, 32'd3);
    rstN = 1'b1;
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b11);
    tick(1);
    checkOutput("empty_grant_ignored", {30'd0, bus.out_valid_o}, 32'd0);

    // Single load, accepted on the first cycle it is presented.
    applyStimulus(2'b01, 4'd3, 4'd0, 2'b00);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b01);
    #1;
    checkOutput("a_valid",  {30'd0, bus.out_valid_o}, 32'd1);
    checkOutput("a_prio0",  {28'd0, bus.out_prio_o[3:0]}, 32'd3);
    checkOutput("a_urgent", {30'd0, bus.out_urgent_o}, 32'd0);
    checkOutput("a_ready",  {30'd0, bus.in_ready_o}, 32'd3);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("a_empty",  {30'd0, bus.out_valid_o}, 32'd0);

    // Escalation every four cycles while held; freezing when disabled.
    applyStimulus(2'b01, 4'd3, 4'd0, 2'b00);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("b_age0_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd3);
    checkOutput("b_held_ready", {30'd0, bus.in_ready_o}, 32'd2);
    tick(3);
    checkOutput("b_age3_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd3);
    tick(1);
    checkOutput("b_age4_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd4);
    tick(4);
    checkOutput("b_age8_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd5);
    tick(4);
    checkOutput("b_age12_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd6);
    qosEnable = 1'b0;
    #1;
    checkOutput("b_disabled_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd3);
    tick(4);
    checkOutput("b_frozen_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd3);
    qosEnable = 1'b1;
    #1;
    checkOutput("b_resumed_prio", {28'd0, bus.out_prio_o[3:0]}, 32'd6);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b01);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("b_accepted", {30'd0, bus.out_valid_o}, 32'd0);

    // Lane 1: saturating priority, urgency at age 32, one starve event.
    applyStimulus(2'b10, 4'd0, 4'd14, 2'b00);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    tick(4);
    checkOutput("c_age4_prio1", {28'd0, bus.out_prio_o[7:4]}, 32'd15);
    tick(27);
    checkOutput("c_age31_urgent", {30'd0, bus.out_urgent_o}, 32'd0);
    checkOutput("c_age31_starve", starveEvents, 32'd0);
    tick(1);
    checkOutput("c_age32_urgent", {30'd0, bus.out_urgent_o}, 32'd2);
    checkOutput("c_age32_starve", starveEvents, 32'd1);
    // A new request while the lane is held must not be taken.
    applyStimulus(2'b10, 4'd0, 4'd2, 2'b00);
    tick(8);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("c_age40_prio1", {28'd0, bus.out_prio_o[7:4]}, 32'd15);
    checkOutput("c_age40_starve", starveEvents, 32'd1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b10);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("c_accepted", {30'd0, bus.out_valid_o}, 32'd0);

    // Both lanes starve on the same edge; saturated ages never re-trigger.
    applyStimulus(2'b11, 4'd0, 4'd0, 2'b00);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    tick(31);
    checkOutput("d_age31_starve", starveEvents, 32'd1);
    tick(1);
    checkOutput("d_age32_starve", starveEvents, 32'd3);
    tick(230);
    checkOutput("d_saturated_starve", starveEvents, 32'd3);
    checkOutput("d_saturated_prio", {24'd0, bus.out_prio_o}, 32'hFF);

    // Accept and reload lane 0 in the same cycle: no bubble, age restarts.
    applyStimulus(2'b01, 4'd7, 4'd0, 2'b01);
    #1;
    checkOutput("e_ready", {30'd0, bus.in_ready_o}, 32'd1);
    tick(1);
    applyStimulus(2'b00, 4'd0, 4'd0, 2'b00);
    checkOutput("e_valid",  {30'd0, bus.out_valid_o}, 32'd3);
    checkOutput("e_prio0",  {28'd0, bus.out_prio_o[3:0]}, 32'd7);
    checkOutput("e_urgent", {30'd0, bus.out_urgent_o}, 32'd2);
    tick(4);
    checkOutput("e_age4_prio0", {28'd0, bus.out_prio_o[3:0]}, 32'd8);

    // Asynchronous reset while lane 0 is at age 20.
    tick(16);
    checkOutput("f_pre_valid", {30'd0, bus.out_valid_o}, 32'd3);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("f_rst_valid",  {30'd0, bus.out_valid_o}, 32'd0);
    checkOutput("f_rst_starve", starveEvents, 32'd0);
    checkOutput("f_rst_ready",  {30'd0, bus.in_ready_o}, 32'd3);
    checkOutput("f_rst_prio",   {24'd0, bus.out_prio_o}, 32'd0);
    tick(1);
    rstN = 1'b1;
    tick(1);
    checkOutput("f_post_valid", {30'd0, bus.out_valid_o}, 32'd0);
    checkOutput("f_post_ready", {30'd0, bus.in_ready_o}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/qos_req_ager.md
QOS_REQ_AGER -- requirements
Module: qos_req_ager

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 2, number of independent request lanes (0 instruction, 1 data).
REQ-002 SHALL have parameter AGE_W, default 8, width of each per-lane age counter.
REQ-003 SHALL have parameter AGE_STEP, default 4, wait cycles per one-level priority escalation; legal range 1..2^AGE_W-1.
REQ-004 SHALL have parameter STARVE_LIMIT, default 32, age at which a lane is flagged urgent; legal range 1..2^AGE_W-1.
REQ-005 SHALL have port clk_i  input  1  single clock, all state rising-edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port qos_enable_i  input  1  enables escalation and urgency.
REQ-008 SHALL have port in_valid_i  input  NUM_REQUESTERS  upstream request valid per lane.
REQ-009 SHALL have port in_prio_i  input  4*NUM_REQUESTERS  base priority per lane, lane k at bits [4k+3:4k].
REQ-010 SHALL have port in_ready_o  output  NUM_REQUESTERS  lane can accept a request.
REQ-011 SHALL have port out_valid_o  output  NUM_REQUESTERS  held request presented to arbiter.
REQ-012 SHALL have port out_prio_o  output  4*NUM_REQUESTERS  effective (aged) priority per lane.
REQ-013 SHALL have port out_urgent_o  output  NUM_REQUESTERS  lane has waited at least STARVE_LIMIT cycles.
REQ-014 SHALL have port out_ready_i  input  NUM_REQUESTERS  arbiter accepted lane this cycle.
REQ-015 SHALL have port starve_events_o  output  32  count of entries that reached STARVE_LIMIT.

Function
REQ-016 Each lane SHALL hold one entry with two states: EMPTY and HELD.
REQ-017 in_ready_o[k] SHALL equal (state EMPTY) or (out_valid_o[k] and out_ready_i[k]), combinationally.
REQ-018 Load SHALL occur when in_valid_i[k] and in_ready_o[k]; next cycle state HELD, out_valid_o[k]=1, stored prio=in_prio_i lane, age=0 (1-cycle latency, no bypass).
REQ-019 Accept SHALL occur when out_valid_o[k] and out_ready_i[k]; without a simultaneous load, next state EMPTY and age=0.
REQ-020 Simultaneous accept and load SHALL replace the entry: stay HELD, new prio, age=0, no bubble.
REQ-021 Age SHALL increment by 1 each cycle lane is HELD and not accepted, saturating at 2^AGE_W-1; it SHALL count regardless of qos_enable_i.
REQ-022 When qos_enable_i=1 and an age increment yields age mod AGE_STEP == 0, effective prio SHALL increment by 1, saturating at 15.
REQ-023 When qos_enable_i=0, out_prio_o SHALL equal stored base prio and escalation SHALL be frozen; re-enabling resumes from escalated value already stored.
REQ-024 out_urgent_o[k] SHALL be 1 iff qos_enable_i=1, lane HELD and age >= STARVE_LIMIT.
REQ-025 starve_events_o SHALL increase by the number of lanes whose age transitions from STARVE_LIMIT-1 to STARVE_LIMIT this cycle, wrapping modulo 2^32.
REQ-026 Each entry SHALL contribute at most one starve event; saturated age SHALL NOT re-trigger.
REQ-027 Lanes SHALL be fully independent; out_ready_i on an EMPTY lane SHALL be ignored.
REQ-028 in_prio_i and in_valid_i SHALL be sampled only at load; changes while HELD SHALL have no effect.

Reset
REQ-029 On rst_ni=0, asynchronously: all lanes EMPTY, ages 0, stored prio 0, out_valid_o=0, out_prio_o=0, out_urgent_o=0, starve_events_o=0.
REQ-030 Reset mid-operation SHALL discard held entries without emitting them; in_ready_o=1 on all lanes while and after reset.

Verification
REQ-031 Load lane0 prio 3, out_ready_i=1 next cycle -> out_valid_o[0]=1 one cycle after load, prio 3, urgent 0, then EMPTY.
REQ-032 Enable=1, lane0 prio 3 held 12 cycles unaccepted -> out_prio_o lane0 steps 4,5,6 at ages 4,8,12.
REQ-033 Enable=1, lane1 prio 14 held 40 cycles -> prio saturates 15; urgent rises at age 32; starve_events_o=1 and stays 1.
REQ-034 Both lanes loaded same cycle, held 32 cycles -> starve_events_o increments by 2 in one cycle.
REQ-035 Lane0 HELD, same cycle out_ready_i=1 and in_valid_i=1 prio 7 -> next cycle out_valid_o stays 1, prio 7, age 0.
REQ-036 Lane0 HELD with age 20, assert rst_ni=0 -> out_valid_o=0 immediately, starve_events_o=0, in_ready_o=1.
